// File: rtl/hazard_stall_ctrl_if.sv
// ============================================================================
//  hazard_stall_ctrl_if : decode-side hazard inputs and execute/stall outputs
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             id_valid;
    logic [31:0]      id_inst;
    logic [3:0]       id_rn;
    logic [3:0]       id_rm;
    logic [3:0]       id_rd;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic             id_reads_rd;
    logic             id_writes_rd;
    logic             flush;
    logic             stall_if;
    logic             stall_id;
    logic             ex_valid;
    logic [31:0]      ex_inst;
    logic             sb_busy;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_inst, id_rn, id_rm, id_rd,
               id_uses_rn, id_uses_rm, id_reads_rd, id_writes_rd, flush,
        input  stall_if, stall_id, ex_valid, ex_inst, sb_busy, stall_count
    );

    modport slave (
        input  id_valid, id_inst, id_rn, id_rm, id_rd,
               id_uses_rn, id_uses_rm, id_reads_rd, id_writes_rd, flush,
        output stall_if, stall_id, ex_valid, ex_inst, sb_busy, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
//  hazard_stall_ctrl : RAW scoreboard, fetch/decode stall and ID->EX handoff
//  Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
    parameter int          DEPTH = 3,
    parameter logic [31:0] NOP   = 32'hE1A00000,
    parameter int          CNT_W = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    hazard_stall_ctrl_if.slave bus
);

    logic [DEPTH-1:0] r_sb_v;
    logic [3:0]       r_sb_rd [DEPTH];
    logic             r_ex_valid;
    logic [31:0]      r_ex_inst;
    logic [CNT_W-1:0] r_stall_count;

    logic w_match_rn;
    logic w_match_rm;
    logic w_match_rd;
    logic w_hazard;
    logic w_stall;
    logic w_issue;

    // r15 is the PC and is never tracked as a hazard source
    always_comb begin
        w_match_rn = 1'b0;
        w_match_rm = 1'b0;
        w_match_rd = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_sb_v[k] && (r_sb_rd[k] == bus.id_rn)) w_match_rn = 1'b1;
            if (r_sb_v[k] && (r_sb_rd[k] == bus.id_rm)) w_match_rm = 1'b1;
            if (r_sb_v[k] && (r_sb_rd[k] == bus.id_rd)) w_match_rd = 1'b1;
        end
        if (bus.id_rn == 4'd15) w_match_rn = 1'b0;
        if (bus.id_rm == 4'd15) w_match_rm = 1'b0;
        if (bus.id_rd == 4'd15) w_match_rd = 1'b0;
    end

    assign w_hazard = (bus.id_uses_rn  & w_match_rn) |
                      (bus.id_uses_rm  & w_match_rm) |
                      (bus.id_reads_rd & w_match_rd);
    assign w_stall  = bus.id_valid & w_hazard & ~bus.flush;
    assign w_issue  = bus.id_valid & ~w_stall & ~bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sb_v        <= '0;
            for (int k = 0; k < DEPTH; k++) r_sb_rd[k] <= 4'd0;
            r_ex_valid    <= 1'b0;
            r_ex_inst     <= NOP;
            r_stall_count <= '0;
        end else begin
            // Oldest entry falls off the top as its regfile write completes
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_sb_v[k]  <= r_sb_v[k-1];
                r_sb_rd[k] <= r_sb_rd[k-1];
            end
            r_sb_v[0]  <= w_issue & bus.id_writes_rd;
            r_sb_rd[0] <= bus.id_rd;

            if (w_issue) begin
                r_ex_valid <= 1'b1;
                r_ex_inst  <= bus.id_inst;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_inst  <= NOP;
            end

            if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign bus.stall_if    = w_stall;
    assign bus.stall_id    = w_stall;
    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_inst     = r_ex_inst;
    assign bus.sb_busy     = |r_sb_v;
    assign bus.stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
//  tb_hazard_stall_ctrl : directed self-checking bench for hazard_stall_ctrl
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    localparam logic [31:0] C_NOP = 32'hE1A00000;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_stall_ctrl_if #(.CNT_W(8)) b ();

    hazard_stall_ctrl #(.DEPTH(3), .NOP(32'hE1A00000), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b.id_valid     = 1'b0;
        b.id_inst      = C_NOP;
        b.id_rn        = 4'd0;
        b.id_rm        = 4'd0;
        b.id_rd        = 4'd0;
        b.id_uses_rn   = 1'b0;
        b.id_uses_rm   = 1'b0;
        b.id_reads_rd  = 1'b0;
        b.id_writes_rd = 1'b0;
        b.flush        = 1'b0;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [3:0] rd, input logic urn, input logic urm,
                         input logic rrd, input logic wrd);
        b.id_valid     = 1'b1;
        b.id_inst      = inst;
        b.id_rn        = rn;
        b.id_rm        = rm;
        b.id_rd        = rd;
        b.id_uses_rn   = urn;
        b.id_uses_rm   = urm;
        b.id_reads_rd  = rrd;
        b.id_writes_rd = wrd;
    endtask

    // Count consecutive stall cycles with the current decode inputs held
    task automatic count_stalls(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (b.stall_if !== 1'b1) break;
            n++;
            tick();
        end
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    initial begin
        int n;
        int n_st;
        checks   = 0;
        failures = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_ex_valid", {31'd0, b.ex_valid}, 32'd0);
        chk("rst_ex_inst",  b.ex_inst, 32'hE1A00000);
        chk("rst_sb_busy",  {31'd0, b.sb_busy}, 32'd0);
        chk("rst_count",    {24'd0, b.stall_count}, 32'd0);
        chk("rst_stall",    {31'd0, b.stall_if}, 32'd0);

        // 1: back-to-back dependence on r4
        drive(32'hE2844001, 4'd4, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("t1_add_nostall", {31'd0, b.stall_if}, 32'd0);
        tick();
        chk("t1_add_ex", b.ex_inst, 32'hE2844001);
        chk("t1_add_exv", {31'd0, b.ex_valid}, 32'd1);
        chk("t1_busy", {31'd0, b.sb_busy}, 32'd1);
        drive(32'hE2442007, 4'd4, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t1_stall_if", {31'd0, b.stall_if}, 32'd1);
            chk("t1_stall_id", {31'd0, b.stall_id}, 32'd1);
            tick();
            chk("t1_bubble_v", {31'd0, b.ex_valid}, 32'd0);
            chk("t1_bubble", b.ex_inst, 32'hE1A00000);
        end
        #1 chk("t1_released", {31'd0, b.stall_if}, 32'd0);
        tick();
        chk("t1_sub_ex", b.ex_inst, 32'hE2442007);
        chk("t1_sub_exv", {31'd0, b.ex_valid}, 32'd1);
        chk("t1_count", {24'd0, b.stall_count}, 32'd3);
        drain();
        chk("t1_drained", {31'd0, b.sb_busy}, 32'd0);

        // 2: independent instructions issue back to back
        drive(32'hE2840000, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("t2_add_nostall", {31'd0, b.stall_if}, 32'd0);
        tick();
        chk("t2_add_ex", b.ex_inst, 32'hE2840000);
        drive(32'hE2432007, 4'd3, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("t2_sub_nostall", {31'd0, b.stall_if}, 32'd0);
        tick();
        chk("t2_sub_ex", b.ex_inst, 32'hE2432007);
        chk("t2_sub_exv", {31'd0, b.ex_valid}, 32'd1);
        drain();

        // 3: store data dependence at distance 1 and 2
        drive(32'hE2845000, 4'd4, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'hE5825000, 4'd2, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        count_stalls(n);
        chk("t3_d1_stalls", n, 32'd3);
        tick();
        chk("t3_str_ex", b.ex_inst, 32'hE5825000);
        drain();
        drive(32'hE2845000, 4'd4, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'hE2840000, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'hE5825000, 4'd2, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        count_stalls(n);
        chk("t3_d2_stalls", n, 32'd2);
        tick();
        chk("t3_str2_ex", b.ex_inst, 32'hE5825000);
        chk("t3_count", {24'd0, b.stall_count}, 32'd8);
        drain();

        // 4: r15 and CMP never create hazards
        drive(32'hE1A0F000, 4'd0, 4'd0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(32'hE59F1000, 4'd15, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("t4_r15_nostall", {31'd0, b.stall_if}, 32'd0);
        tick();
        chk("t4_ldr_ex", b.ex_inst, 32'hE59F1000);
        drive(32'hE3530000, 4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'hE2836001, 4'd3, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("t4_cmp_nostall", {31'd0, b.stall_if}, 32'd0);
        tick();
        chk("t4_add_ex", b.ex_inst, 32'hE2836001);
        drain();

        // 5: flush during the second stall cycle
        drive(32'hE2844001, 4'd4, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'hE2442007, 4'd4, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("t5_stall1", {31'd0, b.stall_if}, 32'd1);
        tick();
        #1 chk("t5_stall2", {31'd0, b.stall_if}, 32'd1);
        b.flush = 1'b1;
        #1 chk("t5_flush_nostall", {31'd0, b.stall_if}, 32'd0);
        tick();
        chk("t5_flush_exv", {31'd0, b.ex_valid}, 32'd0);
        chk("t5_flush_ex", b.ex_inst, 32'hE1A00000);
        chk("t5_busy", {31'd0, b.sb_busy}, 32'd1);
        idle();
        tick();
        chk("t5_retired", {31'd0, b.sb_busy}, 32'd0);
        chk("t5_count", {24'd0, b.stall_count}, 32'd9);

        // 6: asynchronous reset while stalled with a valid instruction in EX
        drive(32'hE2844001, 4'd4, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'hE2442007, 4'd4, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("t6_pre_stall", {31'd0, b.stall_if}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_stall", {31'd0, b.stall_if}, 32'd0);
        chk("t6_exv", {31'd0, b.ex_valid}, 32'd0);
        chk("t6_busy", {31'd0, b.sb_busy}, 32'd0);
        chk("t6_count", {24'd0, b.stall_count}, 32'd0);
        chk("t6_ex_inst", b.ex_inst, 32'hE1A00000);
        tick();
        reset = 1'b0;

        // Saturation: SUB r4,r4,#7 held in decode depends on itself forever
        drive(32'hE2444007, 4'd4, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        n_st = 0;
        for (int i = 0; i < 440; i++) begin
            #1;
            if (b.stall_if === 1'b1) n_st++;
            tick();
        end
        chk("sat_enough", (n_st >= 300) ? 32'd1 : 32'd0, 32'd1);
        chk("sat_count", {24'd0, b.stall_count}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Resolves the read-after-write hazards flagged between decode and in-flight instructions in the 5-stage ARM pipeline.
A DEPTH-entry scoreboard shift register records destination registers of instructions issued from decode until they write back.
When a decode-stage source matches a pending destination, the block freezes fetch/decode and injects a NOP bubble into execute.
It also registers the decode-to-execute instruction handoff and squashes decode on branch flush.

Parameters:
DEPTH, 3, cycles from issue (ID->EX edge) until regfile write completes; scoreboard entries
NOP, 32'hE1A00000, bubble encoding (MOV r0, r0)
CNT_W, 8, width of stall performance counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode stage holds a real instruction
id_inst  in  32  decode-stage instruction word
id_rn  in  4  first source register
id_rm  in  4  second source register
id_rd  in  4  destination register (also store-data source)
id_uses_rn  in  1  instruction reads rn
id_uses_rm  in  1  instruction reads rm (register-operand forms only)
id_reads_rd  in  1  instruction reads rd (STR data)
id_writes_rd  in  1  instruction writes rd (data-processing except CMP/TST, LDR)
flush  in  1  branch taken; squash decode instruction this cycle
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
ex_valid  out  1  registered: execute stage holds a real instruction
ex_inst  out  32  registered: instruction entering execute (NOP when bubble)
sb_busy  out  1  any scoreboard entry valid
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard: entries 0..DEPTH-1, each {v, rd[3:0]}. Entry k holds the instruction issued k+1 edges ago.
- Each edge: entries shift up; entry DEPTH-1 retires (its regfile write completes on that edge).
- Entry 0 loads {1, id_rd} when issuing with id_writes_rd=1; otherwise it loads {0, x}.
- issue = id_valid & !stall & !flush.
- match(r) = OR over k of (v[k] & rd[k]==r & r!=4'd15). r15 (PC) never causes a hazard.
- hazard = (id_uses_rn & match(id_rn)) | (id_uses_rm & match(id_rm)) | (id_reads_rd & match(id_rd)).
- stall = id_valid & hazard & !flush. Combinational, same cycle. stall_if = stall_id = stall.
- ex path on each edge:
  - if issue: ex_inst <= id_inst, ex_valid <= 1.
  - else: ex_inst <= NOP, ex_valid <= 0.
- Back-to-back dependence stalls exactly DEPTH cycles. Dependence at distance d (1 <= d <= DEPTH) stalls DEPTH-d+1 cycles. Distance > DEPTH causes no stall.
- Flush has priority over stall:
  - stall forced 0 and decode instruction squashed (bubble into EX).
  - Existing scoreboard entries keep shifting; older instructions still retire.
- A stalled instruction re-evaluates every cycle. No state is kept about it; its inputs are held by the stalled IF/ID.
- Multiple matching entries: stall persists until the youngest matching entry retires.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- sb_busy = OR of all v[k].
- Reset (async, any time including mid-stall):
  - all v cleared, so stall deasserts immediately.
  - ex_inst=NOP, ex_valid=0, stall_count=0.
- Equal register numbers with id_writes_rd=0 (e.g. CMP) never create scoreboard entries.

Test Plan:
1. DEPTH=3. Issue ADD r4,r4,#1, then SUB r2,r4,#7 in decode the next cycle -> stall high exactly 3 cycles, ex_inst=NOP for those 3 edges, SUB enters EX on the 4th edge, stall_count=3.
2. ADD r0,r4,#0, then SUB r2,r3,#7 -> stall never asserts; both issue on consecutive edges with ex_valid=1.
3. ADD r5,r4,#0, then STR r5,[r2] (id_reads_rd=1) -> 3-cycle stall. Repeat with ADD r0 and one unrelated instruction in between -> 2-cycle stall.
4. MOV r15-target not written, then instruction with id_rn=15 uses_rn=1 while an entry holds rd=15 -> no stall. CMP r3,#0 followed by reader of r3 -> no stall.
5. Stall in progress (cycle 2 of 3), assert flush for one cycle -> stall=0 that cycle, ex_valid=0 next edge, sb_busy stays 1 until the pending entry retires.
6. Assert reset asynchronously mid-stall -> stall, ex_valid, sb_busy, stall_count go 0 without a clock edge and ex_inst=32'hE1A00000. Saturation: force 300 stall cycles with CNT_W=8 -> stall_count=255.
